// File: rtl/cr_fifo_rd_drain.sv
// Read-domain FIFO drain: pops a 1-cycle-latency FIFO into an N_OBUF-deep buffer and
// presents a valid/ready stream with a flush FSM. Optional counters: CR_FIFO_RD_DRAIN_STATS_EN.
module cr_fifo_rd_drain #(
  parameter int N_DATA_BITS = 64,
  parameter int N_OBUF      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_DATA_BITS-1:0] fifo_rdata,
  input  logic                   fifo_empty,
  input  logic                   fifo_aempty,
  output logic                   fifo_ren,
  output logic [N_DATA_BITS-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic                   flush_done,
  output logic                   busy
`ifdef CR_FIFO_RD_DRAIN_STATS_EN
  ,
  output logic [31:0]            pop_cnt,
  output logic [31:0]            stall_cnt
`endif
);

  localparam int            PW    = (N_OBUF > 1) ? $clog2(N_OBUF) : 1;
  localparam int            CW    = $clog2(N_OBUF + 1);
  localparam logic [CW:0]   DEPTH = (CW+1)'(N_OBUF);
  localparam logic [PW-1:0] LAST  = PW'(N_OBUF - 1);

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;

  logic [N_DATA_BITS-1:0] obuf [N_OBUF];
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]          occ;
  logic                   inflight, pop_out, capture, tail_gap, flush_go;
  logic [CW:0]            pend;

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign out_valid = (occ != '0) && (state == RUN);
  assign out_data  = obuf[rd_ptr];
  assign pop_out   = out_valid && out_ready;
  assign flush_go  = flush && (state == RUN);
  // Read data returning after a flush request is dropped, never buffered.
  assign capture   = inflight && (state == RUN) && !flush;
  // Back-to-back pop into almost-empty: leave a gap in case empty lags by a cycle.
  assign tail_gap  = inflight && fifo_aempty;
  // Words committed to the buffer after this edge, counting the one still in flight.
  assign pend      = (CW+1)'(occ) + (CW+1)'(inflight) - (CW+1)'(pop_out);

  always_comb begin
    state_nxt  = state;
    fifo_ren   = 1'b0;
    flush_done = 1'b0;
    busy       = 1'b0;
    case (state)
      RUN: begin
        fifo_ren = !fifo_empty && !tail_gap && (pend < DEPTH);
        if (flush) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy     = 1'b1;
        fifo_ren = !fifo_empty && !tail_gap;
        if (fifo_empty && !inflight) state_nxt = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        state_nxt  = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (rst) fifo_ren = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      inflight <= 1'b0;
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < N_OBUF; i++) obuf[i] <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_ren;
      if (flush_go) begin
        occ    <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (capture) begin
          obuf[wr_ptr] <= fifo_rdata;
          wr_ptr       <= nxt_ptr(wr_ptr);
        end
        if (pop_out) rd_ptr <= nxt_ptr(rd_ptr);
        occ <= occ + CW'(capture) - CW'(pop_out);
      end
    end
  end

`ifdef CR_FIFO_RD_DRAIN_STATS_EN
  logic xfer, stall;
  // A handshake in the flush-request cycle belongs to discarded data.
  assign xfer  = pop_out && !flush;
  assign stall = out_valid && !out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (xfer && (pop_cnt != '1))    pop_cnt   <= pop_cnt + 32'd1;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cr_fifo_rd_drain.sv
// Bench for cr_fifo_rd_drain: FIFO model plus in-order scoreboard, a streaming vector table,
// and directed backpressure / flush / reset sequences.
module tb_cr_fifo_rd_drain;
  localparam int W          = 64;
  localparam int NB         = 2;
  localparam int AEMPTY_VAL = 1;

  logic         clk = 1'b0, rst = 1'b1;
  logic [W-1:0] fifo_rdata = '0;
  logic         fifo_empty = 1'b1, fifo_aempty = 1'b1;
  logic         fifo_ren;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         flush = 1'b0;
  logic         flush_done, busy;
`ifdef CR_FIFO_RD_DRAIN_STATS_EN
  logic [31:0]  pop_cnt, stall_cnt;
`endif

  cr_fifo_rd_drain #(.N_DATA_BITS(W), .N_OBUF(NB)) dut (
    .clk(clk), .rst(rst),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_aempty(fifo_aempty),
    .fifo_ren(fifo_ren),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .flush_done(flush_done), .busy(busy)
`ifdef CR_FIFO_RD_DRAIN_STATS_EN
    , .pop_cnt(pop_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // FIFO read port: registered data, empty/aempty reflect the pop taken at the same edge.
  logic [W-1:0] fq[$];
  always @(posedge clk) begin
    if (fifo_ren && fq.size() > 0) fifo_rdata <= fq.pop_front();
    fifo_empty  <= (fq.size() == 0);
    fifo_aempty <= (fq.size() <= AEMPTY_VAL);
  end

  int           checks = 0, failures = 0;
  logic [W-1:0] exp_q[$];
  int           popped = 0, delivered = 0, m_pop = 0, m_stall = 0;
  bit           draining = 0;
  logic [W-1:0] first_word = '0;

  typedef struct {
    logic         rdy;
    logic         ren;
    logic         vld;
    logic [W-1:0] data;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic observe();
    chk("ren_while_empty", fifo_ren && fifo_empty, 0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_word", out_data, '1);
      else chk("stream_word", out_data, exp_q.pop_front());
      if (delivered == 0) first_word = out_data;
      delivered++;
      m_pop++;
    end
    if (out_valid && !out_ready) m_stall++;
    if (fifo_ren) popped++;
    if (!draining) chk("outstanding_le_nobuf", (popped - delivered) > NB, 0);
    if (flush_done) begin
      draining  = 0;
      popped    = 0;
      delivered = 0;
    end
  endtask

  task automatic step(input logic rdy, input logic fl);
    @(posedge clk); #1;
    out_ready = rdy;
    flush     = fl;
    if (fl) begin
      exp_q.delete();
      draining = 1;
    end
    @(negedge clk);
    observe();
  endtask

  // Anything still in the FIFO survives reset; anything already popped is lost.
  task automatic do_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q = fq;
    popped = 0; delivered = 0; m_pop = 0; m_stall = 0; draining = 0;
  endtask

  task automatic drain(input string name, input int bound, input logic toggle);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step(toggle ? n[0] : 1'b1, 1'b0);
      n++;
    end
    chk(name, exp_q.size(), 0);
    repeat (4) step(1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int nren, nfd;
    // cycle: {out_ready, fifo_ren, out_valid, out_data}; 8 words preloaded at cycle 0
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 64'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 64'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 64'h1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 64'h2};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 64'h3};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 64'h4};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 64'h5};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 64'h6};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 64'h7};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 64'h0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 64'h8};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 64'h0};

    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ren", fifo_ren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", flush_done, 0);
    do_reset();

    // streaming with the aempty tail gap
    for (int i = 0; i < 8; i++) push(W'(i + 1));
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rdy, 1'b0);
      chk($sformatf("tbl_ren_c%0d", i + 1), fifo_ren, tbl[i].ren);
      chk($sformatf("tbl_vld_c%0d", i + 1), out_valid, tbl[i].vld);
      if (tbl[i].vld) chk($sformatf("tbl_data_c%0d", i + 1), out_data, tbl[i].data);
      chk("tbl_busy", busy, 0);
    end
    drain("stream_drain", 20, 1'b0);

    // backpressure: buffer fills to N_OBUF, head held
    do_reset();
    for (int i = 0; i < 6; i++) push(W'(i + 1));
    nren = 0;
    for (int c = 1; c <= 10; c++) begin
      step(1'b0, 1'b0);
      if (fifo_ren) nren++;
      if (c >= 3) begin
        chk("bp_valid", out_valid, 1);
        chk("bp_head_held", out_data, 1);
      end
    end
    chk("bp_pops", nren, NB);
    drain("bp_drain", 40, 1'b0);

    // alternating ready
    do_reset();
    for (int i = 0; i < 16; i++) push(W'(32'h100 + i));
    drain("toggle_drain", 200, 1'b1);

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) != 0) push({$urandom, $urandom});
      step($urandom_range(0, 3) != 0, 1'b0);
    end
    drain("rand_drain", 600, 1'b0);

    // flush with 2 buffered and 5 queued
    do_reset();
    for (int i = 0; i < 7; i++) push(W'(32'h200 + i));
    repeat (5) step(1'b0, 1'b0);
    chk("pre_flush_valid", out_valid, 1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("flush_valid_low", out_valid, 0);
    chk("flush_busy", busy, 1);
    nfd = 0;
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 1'b0);
      if (flush_done) nfd++;
    end
    chk("flush_done_pulses", nfd, 1);
    chk("flush_fifo_left", fq.size(), 0);
    chk("flush_busy_end", busy, 0);
    push(W'(32'hAA));
    drain("flush_aa_drain", 20, 1'b0);
    chk("flush_first_word", first_word, W'(32'hAA));

    // reset with one word buffered and one in flight
    do_reset();
    for (int i = 0; i < 6; i++) push(W'(32'h300 + i));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("mid_valid", out_valid, 1);
    chk("mid_data", out_data, W'(32'h300));
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_ren", fifo_ren, 0);
    chk("async_rst_busy", busy, 0);
    do_reset();
    drain("rst_drain", 30, 1'b0);
    chk("rst_first_word", first_word, W'(32'h302));

`ifdef CR_FIFO_RD_DRAIN_STATS_EN
    do_reset();
    for (int i = 0; i < 10; i++) push(W'(32'h400 + i));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    drain("stats_drain", 30, 1'b0);
    chk("stats_pop_cnt", pop_cnt, 10);
    chk("stats_stall_cnt", stall_cnt, 4);
    for (int i = 0; i < 3; i++) push(W'(32'h500 + i));
    repeat (5) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (30) step(1'b0, 1'b0);
    chk("stats_pop_after_flush", pop_cnt, 10);
    chk("stats_stall_after_flush", stall_cnt, W'(m_stall));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
